// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage: datapath width, FSM states, fault codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0 -- harmless instruction left in the IR after reset
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_MISALIGN = 2'd1,
        FC_TIMEOUT  = 2'd2
    } fault_cause_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: req/ack handshake with address out and data back.
// Latency: set by memory; data is valid in the same cycle as mem_ack.
// Backpressure: requester holds mem_req and mem_addr until mem_ack (or it aborts).
//   master: mem_req, mem_addr out; mem_ack, mem_rdata in (fetch side)
//   slave : mirror image (memory side)
interface fetch_unit_if;
    import cpu_pkg::*;

    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/fetch_timer.sv
// Clearable saturating up-counter flagging the last allowed cycle of a memory wait.
// Latency: tc is a combinational decode of the registered count.
// Backpressure: none; counts while en is high, holds at TIMEOUT, never wraps.
//   clk, rst : clock and synchronous active-high reset
//   clr      : force count to zero (has priority over en)
//   en       : advance by one
//   tc       : count has reached TIMEOUT-1
module fetch_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != W'(TIMEOUT))) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: samples an address from the shared bus, reads memory, latches the IR.
// Latency: start-to-done is 2 cycles minimum (start edge, then ack in first REQ cycle).
// Backpressure: waits on mem_ack up to TIMEOUT cycles, then reports a timeout fault.
//   clk, rst          : clock, synchronous active-high reset
//   start, flush      : begin a fetch from the bus address / abort to IDLE
//   ir_rd, bus        : drive IR onto the tristate bus / shared datapath bus
//   mem               : instruction-memory read port (master side)
//   instr             : instruction register to decode
//   busy, done, fault : registered status; fault_cause says why the fault happened
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              TIMEOUT     = 16,
    parameter logic [XLEN-1:0] RESET_INSTR = NOP_INSTR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                flush,
    input  logic                ir_rd,
    inout  wire  [XLEN-1:0]     bus,
    fetch_unit_if.master        mem,
    output logic [XLEN-1:0]     instr,
    output logic                busy,
    output logic                done,
    output logic                fault,
    output fault_cause_t        fault_cause
);

    fetch_state_t    state;
    logic [XLEN-1:0] addr;
    logic            req_q;
    logic            tmr_tc;

    // Timer runs only while waiting in REQ, so it is always zero on REQ entry.
    fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (state != REQ),
        .en  ((state == REQ) && !mem.mem_ack),
        .tc  (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            instr       <= RESET_INSTR;
            req_q       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= FC_NONE;
        end else if (flush) begin
            // Abort wins over start and over any ack arriving this cycle.
            state       <= IDLE;
            req_q       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= FC_NONE;
        end else begin
            case (state)
                REQ: begin
                    if (mem.mem_ack) begin
                        instr <= mem.mem_rdata;
                        state <= DONE;
                        req_q <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (tmr_tc) begin
                        state       <= FAULT;
                        req_q       <= 1'b0;
                        busy        <= 1'b0;
                        fault       <= 1'b1;
                        fault_cause <= FC_TIMEOUT;
                    end
                end
                default: begin  // IDLE, DONE, FAULT all accept a new start
                    done <= 1'b0;
                    if (start) begin
                        addr <= bus;
                        if (bus[1:0] != 2'b00) begin
                            // Misaligned: fault straight away, memory never sees it.
                            state       <= FAULT;
                            fault       <= 1'b1;
                            fault_cause <= FC_MISALIGN;
                        end else begin
                            state       <= REQ;
                            req_q       <= 1'b1;
                            busy        <= 1'b1;
                            fault       <= 1'b0;
                            fault_cause <= FC_NONE;
                        end
                    end else if (state == DONE) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr;

    assign bus = ir_rd ? instr : 'z;

endmodule
